hash_drbg_stream: RTL and testbench
===================================

# hash_drbg_stream

Parametrised Hash_DRBG (SHA-256) generator with multi-block output streaming, valid/ready backpressure, per-request block count and explicit request rejection. It sits between the entropy/seed source and the video scrambler keystream consumer, and drives the shared external SHA-256 core through a single-message request port. The block replaces the single-word generator: one generate request now yields 1..MAX_BLOCKS 256-bit words from one V state.

## Interface
- SEEDLEN, 256: V/C/entropy width; only 256 is legal, and other values are a fatal elaboration check.
- MAX_BLOCKS, 4: maximum words per generate request, 1..16.
- RESEED_INTERVAL, 37500: number of generate requests allowed per instantiation.
- PERS_STRING, 191'h1E95B49C757C476AD85EA4A86FFD9: personalization string, zero-extended to 191 bits.
- BW, $clog2(MAX_BLOCKS+1): width of gen_blocks.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset; zeroizes all state.
- entropy  in  SEEDLEN  seed, sampled in the instantiate-accept cycle only.
- inst_req  in  1  instantiate/reseed request, single-cycle pulse.
- gen_req  in  1  generate request, single-cycle pulse.
- gen_blocks  in  BW  words requested, sampled with gen_req.
- rnd_data  out  256  output word.
- rnd_valid  out  1  rnd_data valid; held until rnd_ready.
- rnd_ready  in  1  consumer accept.
- rnd_last  out  1  qualifies the final word of a request.
- busy  out  1  FSM not in IDLE.
- instantiated  out  1  V/C valid.
- reseed_required  out  1  reseed_counter > RESEED_INTERVAL.
- gen_error  out  1  one-cycle pulse when gen_req is rejected.
- sha_init  out  1  one-cycle start pulse to the SHA core.
- sha_block  out  512  padded message, stable from sha_init until digest_valid.
- sha_ready  in  1  SHA core idle.
- sha_digest  in  256  digest.
- sha_digest_valid  in  1  digest strobe.

## Operation
- States: IDLE, INST_V, INST_C, GEN_W, GEN_OUT, GEN_H, UPD_V. Each hashing state has an ISSUE sub-phase and a WAIT sub-phase.
  - ISSUE: when sha_ready=1, drive sha_block and pulse sha_init for 1 cycle.
  - WAIT: capture sha_digest in the cycle sha_digest_valid=1.
- Messages (MSB first):
  - INST_V: {entropy, PERS_STRING, 1'b1, 64'd447}.
  - INST_C: {8'h00, V, 1'b1, 183'b0, 64'd264}.
  - GEN_W: {data, 1'b1, 191'b0, 64'd256}.
  - GEN_H: {8'h03, V, 1'b1, 183'b0, 64'd264}.
- Instantiate:
  - inst_req is accepted only in IDLE. It is ignored while busy and produces no error.
  - IDLE→INST_V: V := digest.
  - INST_V→INST_C: C := digest; instantiated := 1; reseed_counter := 1; return to IDLE.
- Generate:
  - gen_req in IDLE is rejected (gen_error=1, state unchanged) if any of the following hold: instantiated=0, reseed_required=1, gen_blocks=0, or gen_blocks>MAX_BLOCKS.
  - gen_req while busy is ignored.
  - On accept: data := V; remaining := gen_blocks.
  - GEN_W→GEN_OUT: rnd_data := digest; rnd_valid := 1; rnd_last := (remaining==1).
  - In GEN_OUT, on rnd_valid&&rnd_ready: data := data+1 (mod 2^256); remaining -= 1. Go to GEN_W if remaining>0, else GEN_H.
  - GEN_H→UPD_V: V := V + digest + C + reseed_counter, all mod 2^256; reseed_counter zero-extended to 256 bits. Then reseed_counter += 1 and return to IDLE.
- reseed_counter is 64 bits and saturates at all-ones.
- Reseed is a fresh instantiate (inst_req with new entropy). It clears reseed_required after INST_C completes.

## Timing
- Reset values of all outputs are 0: rnd_data, rnd_valid, rnd_last, busy, instantiated, reseed_required, gen_error, sha_init, sha_block. V, C, data and reseed_counter are also 0.
- Reset mid-operation aborts immediately. sha_init drops to 0 asynchronously, and any digest arriving after reset is ignored.
- Request accept: busy=1 from the cycle after the gen_req/inst_req cycle.
- sha_init latency:
  - 1 cycle after state entry if sha_ready=1.
  - Otherwise, 1 cycle after sha_ready rises.
- A sha_digest_valid that is not in WAIT is ignored.
- rnd_valid rises 1 cycle after the GEN_W digest_valid cycle.
- rnd_data, rnd_valid and rnd_last are stable while rnd_ready=0.
- rnd_valid falls in the cycle after the handshake.
- Minimum generate latency with a D-cycle SHA core and rnd_ready tied high: N·(D+3) + (D+4) cycles from gen_req to busy=0.
- gen_error is asserted in the cycle after the gen_req cycle.
- reseed_required is registered and updates the cycle after reseed_counter changes.

## Test plan
- Instantiate with entropy=256'h0 against a bench SHA model (latency 64). Expect:
  - exactly 2 sha_init pulses;
  - V and C equal software Hash_DRBG values;
  - instantiated=1 and busy=0.
- gen_req with gen_blocks=3 and rnd_ready=1. Expect:
  - 3 rnd_valid beats, rnd_last only on beat 3;
  - words match the software model for data=V, V+1, V+2;
  - V updated per the formula; reseed_counter=2.
- Same request with rnd_ready toggled 0/1 every 5 cycles. Expect:
  - rnd_data stable while stalled;
  - no sha_init while in GEN_OUT;
  - results identical to the previous scenario.
- Requests gen_blocks=0, gen_blocks=MAX_BLOCKS+1, and any gen_req before instantiate each produce gen_error=1 for 1 cycle, with busy staying 0.
- RESEED_INTERVAL=3:
  - 3 generates succeed; reseed_required=1 after the third.
  - The 4th generate produces gen_error.
  - inst_req clears reseed_required, and the next generate succeeds.
- reset_n low during GEN_W WAIT:
  - all outputs are 0 next cycle and instantiated=0;
  - a late sha_digest_valid produces no output.

Source files
------------

// File: rtl/hash_drbg_stream.sv
// hash_drbg_stream
//   Hash_DRBG (SHA-256) keystream generator. One generate request yields
//   1..MAX_BLOCKS 256-bit words from a single V state, streamed out over a
//   valid/ready handshake. Hashing is delegated to a shared external SHA-256
//   core through a single-message request port (sha_init/sha_block in,
//   sha_digest/sha_digest_valid back).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset (zeroizes state)
//   entropy               seed, sampled when inst_req is accepted
//   inst_req              instantiate / reseed request pulse
//   gen_req, gen_blocks   generate request pulse and word count
//   rnd_data/valid/last   output word stream, rnd_ready is the consumer accept
//   busy                  FSM not idle
//   instantiated          V/C hold valid seed material
//   reseed_required       reseed counter has exceeded RESEED_INTERVAL
//   gen_error             one-cycle pulse when a gen_req is rejected
//   sha_init, sha_block   SHA core start pulse and padded 512-bit message
//   sha_ready             SHA core idle
//   sha_digest(_valid)    SHA core result and strobe

module hash_drbg_stream #(
  parameter int unsigned  SEEDLEN         = 256,
  parameter int unsigned  MAX_BLOCKS      = 4,
  parameter int unsigned  RESEED_INTERVAL = 37500,
  parameter logic [190:0] PERS_STRING     = 191'h1E95B49C757C476AD85EA4A86FFD9,
  parameter int unsigned  BW              = $clog2(MAX_BLOCKS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SEEDLEN-1:0] entropy,
  input  logic               inst_req,
  input  logic               gen_req,
  input  logic [BW-1:0]      gen_blocks,
  output logic [255:0]       rnd_data,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               rnd_last,
  output logic               busy,
  output logic               instantiated,
  output logic               reseed_required,
  output logic               gen_error,
  output logic               sha_init,
  output logic [511:0]       sha_block,
  input  logic               sha_ready,
  input  logic [255:0]       sha_digest,
  input  logic               sha_digest_valid
);

  if (SEEDLEN != 256) begin : g_seedlen_chk
    $fatal(1, "hash_drbg_stream: SEEDLEN must be 256");
  end
  if (MAX_BLOCKS < 1 || MAX_BLOCKS > 16) begin : g_maxblk_chk
    $fatal(1, "hash_drbg_stream: MAX_BLOCKS must be 1..16");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INST_V,
    ST_INST_C,
    ST_GEN_W,
    ST_GEN_OUT,
    ST_GEN_H,
    ST_UPD_V
  } state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic [SEEDLEN-1:0] ent_q;
  logic [SEEDLEN-1:0] v_q;
  logic [SEEDLEN-1:0] c_q;
  logic [SEEDLEN-1:0] data_q;
  logic [63:0]        reseed_counter;
  logic [BW-1:0]      remaining;

  logic         hashing;
  logic         issue_go;
  logic         cap_go;
  logic         accept_inst;
  logic         accept_gen;
  logic         reject_gen;
  logic         handshake;
  logic         gen_bad;
  logic [511:0] msg;

  assign busy = (state_q != ST_IDLE);

  assign hashing = (state_q == ST_INST_V) || (state_q == ST_INST_C) ||
                   (state_q == ST_GEN_W)  || (state_q == ST_GEN_H);

  assign gen_bad = !instantiated || reseed_required || (gen_blocks == '0) ||
                   (32'(gen_blocks) > MAX_BLOCKS);

  // Padded single-block SHA-256 messages, one per hashing state.
  always_comb begin
    msg = '0;
    case (state_q)
      ST_INST_V: msg = {ent_q, PERS_STRING, 1'b1, 64'd447};
      ST_INST_C: msg = {8'h00, v_q, 1'b1, 183'b0, 64'd264};
      ST_GEN_W:  msg = {data_q, 1'b1, 191'b0, 64'd256};
      ST_GEN_H:  msg = {8'h03, v_q, 1'b1, 183'b0, 64'd264};
      default:   msg = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    issue_go    = 1'b0;
    cap_go      = 1'b0;
    accept_inst = 1'b0;
    accept_gen  = 1'b0;
    reject_gen  = 1'b0;
    handshake   = 1'b0;

    // Digest strobes outside a WAIT sub-phase are never captured.
    if (hashing) begin
      if (phase_q == PH_ISSUE) begin
        if (sha_ready) begin
          issue_go = 1'b1;
          phase_d  = PH_WAIT;
        end
      end else if (sha_digest_valid) begin
        cap_go = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (inst_req) begin
          accept_inst = 1'b1;
          state_d     = ST_INST_V;
        end else if (gen_req) begin
          if (gen_bad) begin
            reject_gen = 1'b1;
          end else begin
            accept_gen = 1'b1;
            state_d    = ST_GEN_W;
          end
        end
      end
      ST_INST_V: if (cap_go) state_d = ST_INST_C;
      ST_INST_C: if (cap_go) state_d = ST_IDLE;
      ST_GEN_W:  if (cap_go) state_d = ST_GEN_OUT;
      ST_GEN_OUT: begin
        if (rnd_valid && rnd_ready) begin
          handshake = 1'b1;
          state_d   = (remaining == BW'(1)) ? ST_GEN_H : ST_GEN_W;
        end
      end
      ST_GEN_H:  if (cap_go) state_d = ST_UPD_V;
      ST_UPD_V:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d != state_q) phase_d = PH_ISSUE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q           <= '0;
      v_q             <= '0;
      c_q             <= '0;
      data_q          <= '0;
      reseed_counter  <= '0;
      remaining       <= '0;
      rnd_data        <= '0;
      rnd_valid       <= 1'b0;
      rnd_last        <= 1'b0;
      instantiated    <= 1'b0;
      reseed_required <= 1'b0;
      gen_error       <= 1'b0;
      sha_init        <= 1'b0;
      sha_block       <= '0;
    end else begin
      sha_init        <= issue_go;
      gen_error       <= reject_gen;
      // Registered flag: follows reseed_counter one cycle later.
      reseed_required <= (reseed_counter > 64'(RESEED_INTERVAL));

      if (issue_go) sha_block <= msg;
      if (accept_inst) ent_q <= entropy;

      if (accept_gen) begin
        data_q    <= v_q;
        remaining <= gen_blocks;
      end

      if (cap_go) begin
        case (state_q)
          ST_INST_V: v_q <= sha_digest;
          ST_INST_C: begin
            c_q            <= sha_digest;
            instantiated   <= 1'b1;
            reseed_counter <= 64'd1;
          end
          ST_GEN_W: begin
            rnd_data  <= sha_digest;
            rnd_valid <= 1'b1;
            rnd_last  <= (remaining == BW'(1));
          end
          ST_GEN_H: v_q <= v_q + sha_digest + c_q + {192'b0, reseed_counter};
          default: ;
        endcase
      end

      if (handshake) begin
        rnd_valid <= 1'b0;
        rnd_last  <= 1'b0;
        data_q    <= data_q + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (state_q == ST_UPD_V && reseed_counter != '1) begin
        reseed_counter <= reseed_counter + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_hash_drbg_stream.sv
module tb_hash_drbg_stream;

  localparam int unsigned  MAXB = 4;
  localparam int unsigned  RI   = 3;
  localparam int           D    = 64;
  localparam logic [190:0] PERS = 191'h1E95B49C757C476AD85EA4A86FFD9;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] entropy = '0;
  logic         inst_req = 1'b0;
  logic         gen_req = 1'b0;
  logic [2:0]   gen_blocks = '0;
  logic [255:0] rnd_data;
  logic         rnd_valid;
  logic         rnd_ready = 1'b1;
  logic         rnd_last;
  logic         busy;
  logic         instantiated;
  logic         reseed_required;
  logic         gen_error;
  logic         sha_init;
  logic [511:0] sha_block;
  logic         sha_ready = 1'b1;
  logic [255:0] sha_digest = '0;
  logic         sha_digest_valid = 1'b0;

  hash_drbg_stream #(
    .MAX_BLOCKS(MAXB),
    .RESEED_INTERVAL(RI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .entropy(entropy), .inst_req(inst_req),
    .gen_req(gen_req), .gen_blocks(gen_blocks), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_last(rnd_last),
    .busy(busy), .instantiated(instantiated), .reseed_required(reseed_required),
    .gen_error(gen_error), .sha_init(sha_init), .sha_block(sha_block),
    .sha_ready(sha_ready), .sha_digest(sha_digest), .sha_digest_valid(sha_digest_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Stand-in for SHA-256: any fixed mixing of all 512 message bits will do,
  // since the DUT only forwards messages and combines digests.
  function automatic logic [255:0] fh(input logic [511:0] m);
    logic [255:0] a, b;
    a = m[511:256];
    b = m[255:0];
    return (a ^ {b[200:0], b[255:201]}) + {a[100:0], a[255:101]} + (b * 256'd40503);
  endfunction

  // Reference DRBG state and expectations
  logic [255:0] mV, mC;
  logic [63:0]  mctr;
  bit           minst = 0;
  logic [511:0] exp_msg[$];
  logic [256:0] exp_word[$];
  logic [256:0] seen_word[$];
  logic [256:0] ref_words[$];
  int           init_cnt = 0;
  int           sha_gap = 0;
  bit           stall_mode = 0;
  int           cyc = 0;

  function automatic bit model_reject(input int unsigned n);
    return !minst || (mctr > 64'(RI)) || (n == 0) || (n > MAXB);
  endfunction

  task automatic model_gen(input int unsigned n);
    logic [255:0] d, h;
    logic [511:0] m;
    for (int unsigned i = 0; i < n; i++) begin
      d = mV + 256'(i);
      m = {d, 1'b1, 191'b0, 64'd256};
      exp_msg.push_back(m);
      exp_word.push_back({(i == n - 1), fh(m)});
    end
    m = {8'h03, mV, 1'b1, 183'b0, 64'd264};
    exp_msg.push_back(m);
    h = fh(m);
    mV = mV + h + mC + {192'b0, mctr};
    mctr = mctr + 64'd1;
  endtask

  // SHA core model: digest D cycles after sha_init, ready low meanwhile,
  // plus an optional extra gap before ready returns.
  initial begin
    int cnt;
    int gapc;
    logic [511:0] m;
    cnt = -1;
    gapc = 0;
    m = '0;
    forever begin
      @(negedge clk);
      if (sha_digest_valid) begin
        sha_digest_valid = 1'b0;
        gapc = sha_gap;
        if (gapc == 0) sha_ready = 1'b1;
      end else if (gapc > 0) begin
        gapc--;
        if (gapc == 0) sha_ready = 1'b1;
      end
      if (sha_init) begin
        m = sha_block;
        cnt = D;
        sha_ready = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sha_digest = fh(m);
          sha_digest_valid = 1'b1;
          cnt = -1;
        end
      end
    end
  end

  // Monitor: messages, words, stall stability
  initial begin
    bit prev_stall;
    logic [256:0] prev_val;
    logic [511:0] em;
    logic [256:0] ew;
    prev_stall = 0;
    prev_val = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (sha_init) begin
          init_cnt++;
          if (exp_msg.size() == 0) fail_now("unexpected_sha_init");
          else begin
            em = exp_msg.pop_front();
            chk("sha_block", sha_block, em);
            chk("no_init_in_gen_out", 512'(rnd_valid), 512'(0));
          end
        end
        if (prev_stall)
          chk("stall_hold", 512'({rnd_valid, rnd_last, rnd_data}), 512'({1'b1, prev_val}));
        prev_stall = rnd_valid && !rnd_ready;
        prev_val = {rnd_last, rnd_data};
        if (rnd_valid && rnd_ready) begin
          seen_word.push_back({rnd_last, rnd_data});
          if (exp_word.size() == 0) fail_now("unexpected_word");
          else begin
            ew = exp_word.pop_front();
            chk("rnd_word", 512'({rnd_last, rnd_data}), 512'(ew));
          end
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  // rnd_ready toggles every 5 cycles in stall mode
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (stall_mode) rnd_ready = ((cyc / 5) % 2 == 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_inst(input logic [255:0] ent);
    int c0, n;
    logic [511:0] mv, mcm;
    mv = {ent, PERS, 1'b1, 64'd447};
    mV = fh(mv);
    mcm = {8'h00, mV, 1'b1, 183'b0, 64'd264};
    mC = fh(mcm);
    mctr = 64'd1;
    minst = 1;
    exp_msg.push_back(mv);
    exp_msg.push_back(mcm);
    c0 = init_cnt;
    entropy = ent;
    inst_req = 1'b1;
    tick();
    inst_req = 1'b0;
    entropy = {8{$urandom}};
    chk("inst_busy_rise", 512'(busy), 512'(1));
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (busy) fail_now("inst_timeout");
    tick();
    tick();
    chk("inst_pulses", 512'(init_cnt - c0), 512'(2));
    chk("instantiated", 512'(instantiated), 512'(1));
    chk("inst_busy_fall", 512'(busy), 512'(0));
    chk("inst_reseed_clear", 512'(reseed_required), 512'(0));
    chk("inst_msgs_used", 512'(exp_msg.size()), 512'(0));
  endtask

  task automatic run_gen(input int unsigned n, input bit stall, input bit exp_err, output int lat);
    stall_mode = stall;
    if (!stall) rnd_ready = 1'b1;
    if (!exp_err) model_gen(n);
    seen_word.delete();
    gen_blocks = 3'(n);
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    gen_blocks = 3'($urandom);
    lat = 1;
    chk("gen_error_pulse", 512'(gen_error), 512'(exp_err));
    chk("gen_busy", 512'(busy), 512'(!exp_err));
    if (exp_err) begin
      tick();
      chk("gen_error_drop", 512'(gen_error), 512'(0));
      chk("reject_idle", 512'(busy), 512'(0));
    end else begin
      while (busy && lat < 5000) begin tick(); lat++; end
      if (busy) fail_now("gen_timeout");
      tick();
      tick();
      chk("gen_msgs_used", 512'(exp_msg.size()), 512'(0));
      chk("gen_words_used", 512'(exp_word.size()), 512'(0));
      chk("word_count", 512'(seen_word.size()), 512'(n));
      chk("reseed_required", 512'(reseed_required), 512'(mctr > 64'(RI)));
    end
    stall_mode = 0;
    rnd_ready = 1'b1;
  endtask

  typedef struct {
    bit         do_inst;
    logic [2:0] blocks;
    bit         stall;
    bit         exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n, c0, odd;
    tbl[0] = '{1, 3'd1, 0, 0};
    tbl[1] = '{0, 3'd0, 0, 1};
    tbl[2] = '{0, 3'd5, 0, 1};
    tbl[3] = '{0, 3'd2, 1, 0};
    tbl[4] = '{0, 3'd7, 0, 1};
    tbl[5] = '{0, 3'd4, 0, 0};
    tbl[6] = '{0, 3'd2, 0, 1};
    tbl[7] = '{1, 3'd3, 1, 0};
    tbl[8] = '{0, 3'd4, 0, 0};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_outputs", 512'({rnd_data, rnd_valid, rnd_last, busy, instantiated,
                              reseed_required, gen_error, sha_init}), 512'(0));
    chk("reset_sha_block", sha_block, 512'(0));

    // Generate before instantiate
    run_gen(2, 0, 1, lat);

    // Instantiate with zero entropy, then a 3-word generate at full rate
    run_inst('0);
    run_gen(3, 0, 0, lat);
    chk("gen_latency", 512'(lat), 512'(3 * (D + 3) + D + 4));
    chk("ctr_after_gen", 512'(mctr), 512'(2));
    ref_words = seen_word;

    // Same request from the same seed with a stalling consumer
    run_inst('0);
    run_gen(3, 1, 0, lat);
    chk("stall_word_count", 512'(seen_word.size()), 512'(ref_words.size()));
    for (int i = 0; i < 3; i++)
      if (i < seen_word.size() && i < ref_words.size())
        chk("stall_same_words", 512'(seen_word[i]), 512'(ref_words[i]));

    // Table: rejections, reseed limit, reseed recovery
    for (int i = 0; i < 9; i++) begin
      sha_gap = $urandom_range(0, 3);
      if (tbl[i].do_inst) run_inst({8{$urandom}});
      run_gen(tbl[i].blocks, tbl[i].stall, tbl[i].exp_err, lat);
    end

    // Random requests against the reference model
    for (int i = 0; i < 6; i++) begin
      sha_gap = $urandom_range(0, 2);
      n = $urandom_range(0, 7);
      run_gen(n, 1'($urandom), model_reject(n), lat);
      if (mctr > 64'(RI)) run_inst({8{$urandom}});
    end

    // Reset while waiting for a GEN_W digest
    sha_gap = 0;
    exp_msg.push_back({mV, 1'b1, 191'b0, 64'd256});
    c0 = init_cnt;
    gen_blocks = 3'd2;
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    n = 0;
    while (init_cnt == c0 && n < 100) begin tick(); n++; end
    if (init_cnt == c0) fail_now("rst_no_sha_init");
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 512'({rnd_data, rnd_valid, rnd_last, busy, instantiated,
                                reseed_required, gen_error, sha_init}), 512'(0));
    chk("rst_mid_sha_block", sha_block, 512'(0));
    exp_msg.delete();
    exp_word.delete();
    minst = 0;
    tick();
    tick();
    reset_n = 1'b1;
    odd = 0;
    repeat (100) begin
      tick();
      if (rnd_valid || busy || instantiated) odd++;
    end
    chk("late_digest_ignored", 512'(odd), 512'(0));
    run_gen(1, 0, 1, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
